// File: rtl/gray_frame_sequencer.sv
// ============================================================================
// gray_frame_sequencer: raster frame-RAM reader feeding the RGB-to-gray path. Rev 1.0
// ============================================================================
`default_nettype none

module gray_frame_sequencer #(
  parameter int WIDTH         = 200,
  parameter int HEIGHT        = 200,
  parameter int HBLANK        = 4,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic              rgb_valid,
  output logic              rgb_hsync,
  output logic              rgb_vsync,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  input  logic              gray_valid,
  output logic [ADDR_W:0]   gray_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = $clog2(HBLANK + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CW-1:0]   COL_LAST   = CW'(WIDTH - 1);
  localparam logic [LW-1:0]   LINE_LAST  = LW'(HEIGHT - 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'(HBLANK - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [ADDR_W:0] TOTAL      = (ADDR_W + 1)'(WIDTH * HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_HBLANK = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [LW-1:0]   line;
  logic [BW-1:0]   blank_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            rd_d1;
  logic            last_d1;
  logic            rgb_last;
  logic            last_issue;
  logic            accept;
  logic [ADDR_W:0] gray_next;

  assign last_issue = (state == S_ACTIVE) && (col == COL_LAST) && (line == LINE_LAST);
  assign accept     = (state == S_IDLE) && start;
  assign gray_next  = gray_count + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      line      <= '0;
      blank_cnt <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ACTIVE;
            busy      <= 1'b1;
            err       <= 1'b0;
            col       <= '0;
            line      <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (col == COL_LAST) begin
            col       <= '0;
            mem_rd_en <= 1'b0;
            if (line != LINE_LAST) begin
              line      <= line + LW'(1);
              mem_addr  <= mem_addr + ADDR_W'(1);
              blank_cnt <= '0;
              state     <= S_HBLANK;
            end else begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end else begin
            col      <= col + CW'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        S_HBLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            mem_rd_en <= 1'b1;
            state     <= S_ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
        S_DRAIN: begin
          // Finish only on a quiet cycle so a surplus beat still in flight is not missed.
          if (gray_count == TOTAL && !gray_valid && !rd_d1 && !rgb_valid) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (!rd_d1) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (busy && gray_valid && (gray_next > TOTAL)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_count <= '0;
    end else if (!abort) begin
      if (accept) gray_count <= '0;
      else if (busy && gray_valid) gray_count <= gray_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1     <= 1'b0;
      last_d1   <= 1'b0;
      rgb_valid <= 1'b0;
      rgb_hsync <= 1'b0;
      rgb_vsync <= 1'b0;
      rgb_last  <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else if (abort) begin
      rd_d1     <= 1'b0;
      last_d1   <= 1'b0;
      rgb_valid <= 1'b0;
      rgb_hsync <= 1'b0;
      rgb_vsync <= 1'b0;
      rgb_last  <= 1'b0;
    end else begin
      rd_d1     <= mem_rd_en;
      last_d1   <= last_issue;
      rgb_valid <= rd_d1;
      rgb_hsync <= rd_d1;
      rgb_last  <= last_d1;
      if (rd_d1) {r, g, b} <= mem_rdata;
      if (rd_d1) rgb_vsync <= 1'b1;
      else if (rgb_valid && rgb_last) rgb_vsync <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_frame_sequencer.sv
// ============================================================================
// tb_gray_frame_sequencer: scoreboard bench with RAM model and gray loopback. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gray_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int HB    = 2;
  localparam int AW    = 4;
  localparam int DT    = 16;
  localparam int TOTAL = W * H;
  localparam int VS_LEN = (H - 1) * (W + HB) + W;

  logic clk = 1'b0;
  logic rst_n, start, abort, gray_valid;
  logic busy, done, err, mem_rd_en, rgb_valid, rgb_hsync, rgb_vsync;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata;
  logic [7:0]    r, g, b;
  logic [AW:0]   gray_count;

  always #5 clk = ~clk;

  gray_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .ADDR_W(AW), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rgb_valid(rgb_valid), .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync),
    .r(r), .g(g), .b(b),
    .gray_valid(gray_valid), .gray_count(gray_count)
  );

  // Synchronous frame RAM and a one-cycle gray loopback with optional surplus beat.
  logic [23:0] ram [16];
  bit loop_en, inject, lb;
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];
  always @(negedge clk) lb = rgb_valid;
  always @(posedge clk) begin
    #1;
    gray_valid = (loop_en & lb) | inject;
  end

  typedef struct packed {
    logic        err;
    logic [AW:0] cnt;
    logic        tmo;
  } done_t;

  logic [AW-1:0] addr_q[$];
  logic [23:0]   pix_q[$];
  int            off_q[$];
  done_t         done_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, first_rd_cyc = 0, first_v_cyc = 0, last_v_cyc = 0, vs_cnt = 0, done_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, a pixel or a done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        if (addr_q.size() == 0) check("unexpected read", 1, 0);
        else begin
          automatic logic [AW-1:0] ea = addr_q.pop_front();
          if (ea == 0) first_rd_cyc = cyc;
          check("mem_addr", mem_addr, ea);
        end
      end
      if (rgb_valid || rgb_hsync) check("hsync vs valid", rgb_hsync, rgb_valid);
      if (rgb_valid) begin
        if (pix_q.size() == 0) check("unexpected pixel", 1, 0);
        else begin
          automatic logic [23:0] ep = pix_q.pop_front();
          automatic int eo = off_q.pop_front();
          if (eo == 0) begin
            first_v_cyc = cyc;
            check("first pixel latency", cyc - first_rd_cyc, 2);
          end
          check("rgb", {r, g, b}, ep);
          check("pixel slot", cyc - first_v_cyc, eo);
          last_v_cyc = cyc;
        end
      end
      if (rgb_vsync) vs_cnt++;
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) check("unexpected done", 1, 0);
        else begin
          automatic done_t ed = done_q.pop_front();
          check("err at done", err, ed.err);
          check("gray_count at done", gray_count, ed.cnt);
          if (ed.tmo) check("timeout delay", cyc - last_v_cyc, DT);
        end
      end
    end
  end

  task automatic fill_ram(input bit seq);
    for (int i = 0; i < 16; i++)
      ram[i] = seq ? {8'(i), 8'(i + 1), 8'(i + 2)} : 24'($urandom);
  endtask

  task automatic push_frame(input int naddr, input int npix);
    for (int k = 0; k < naddr; k++) addr_q.push_back(AW'(k));
    for (int k = 0; k < npix; k++) begin
      pix_q.push_back(ram[k]);
      off_q.push_back((k / W) * (W + HB) + (k % W));
    end
  endtask

  task automatic do_start();
    vs_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy after start", busy, 1);
    check("err cleared on start", err, 0);
    check("gray_count cleared on start", gray_count, 0);
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int s;
    bit seen;
    s = done_seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_seen != s) seen = 1;
    end
    if (!seen) check("done within budget", 0, 1);
    else begin
      check("busy low in done cycle", busy, 0);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("done is one cycle", done, 0);
      if (poke) check("start in done cycle ignored", busy, 0);
    end
  endtask

  task automatic post_frame();
    check("vsync length", vs_cnt, VS_LEN);
    check("pixel queue drained", pix_q.size(), 0);
    check("addr queue drained", addr_q.size(), 0);
    check("done queue drained", done_q.size(), 0);
  endtask

  task automatic wait_read(input int a, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd_en && mem_addr == AW'(a)) hit = 1;
    end
    if (!hit) check("read address reached", 0, 1);
  endtask

  task automatic good_frame(input bit seq);
    fill_ram(seq);
    loop_en = 1;
    push_frame(TOTAL, TOTAL);
    done_q.push_back('{err: 1'b0, cnt: (AW + 1)'(TOTAL), tmo: 1'b0});
    do_start();
    wait_done(100, 0);
    post_frame();
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; inject = 0; loop_en = 1;
    gray_valid = 1'b0;
    fill_ram(1);
    #1;
    check("reset flags", {busy, done, err, mem_rd_en, rgb_valid, rgb_hsync, rgb_vsync}, 0);
    check("reset data", {mem_addr, r, g, b, gray_count}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known ramp frame, then randomized frames.
    good_frame(1);
    for (int n = 0; n < 3; n++) good_frame(0);

    // No gray returns: timeout, plus a start poked into the DONE cycle.
    fill_ram(0);
    loop_en = 0;
    push_frame(TOTAL, TOTAL);
    done_q.push_back('{err: 1'b1, cnt: '0, tmo: 1'b1});
    do_start();
    wait_done(100, 1);
    post_frame();

    // Start held high for 20 cycles mid-frame: one frame only.
    fill_ram(0);
    push_frame(TOTAL, TOTAL);
    done_q.push_back('{err: 1'b1, cnt: '0, tmo: 1'b1});
    do_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(100, 0);
    repeat (5) @(negedge clk);
    #1;
    check("no restart after held start", busy, 0);
    post_frame();

    // Surplus gray beat placed in the line gap.
    fill_ram(0);
    loop_en = 1;
    push_frame(TOTAL, TOTAL);
    done_q.push_back('{err: 1'b1, cnt: (AW + 1)'(TOTAL + 1), tmo: 1'b1});
    do_start();
    wait_read(W - 1, 20);
    repeat (3) @(negedge clk);
    inject = 1;
    @(negedge clk);
    inject = 0;
    wait_done(100, 0);
    post_frame();

    // Abort while reading the third pixel of line 1.
    fill_ram(0);
    push_frame(W + 3, W + 1);
    do_start();
    wait_read(W + 2, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort flushes", {mem_rd_en, rgb_valid, rgb_vsync, busy}, 0);
    check("abort keeps err", err, 0);
    begin
      int s;
      s = done_seen;
      repeat (30) @(negedge clk);
      #1;
      check("no done after abort", done_seen - s, 0);
    end
    check("abort pixel queue", pix_q.size(), 0);
    check("abort addr queue", addr_q.size(), 0);
    good_frame(0);

    // Async reset pulse mid-line.
    fill_ram(0);
    push_frame(TOTAL, TOTAL);
    do_start();
    wait_read(W + 1, 20);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("mid-frame reset flags", {busy, done, err, mem_rd_en, rgb_valid, rgb_hsync, rgb_vsync}, 0);
    check("mid-frame reset data", {mem_addr, r, g, b, gray_count}, 0);
    #0.5;
    rst_n = 1'b1;
    addr_q.delete();
    pix_q.delete();
    off_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("idle after reset", {busy, mem_rd_en}, 0);
    good_frame(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_frame_sequencer.md
Name: gray_frame_sequencer

Overview:
- Frame-level controller that feeds the RGB888-to-gray datapath from a synchronous frame RAM.
- On a start pulse it reads WIDTH*HEIGHT pixels in raster order and drives rgb_valid/rgb_hsync/rgb_vsync/r/g/b with programmable horizontal blanking.
- It counts returning gray_valid beats and reports completion, or a timeout error, to the host.

Parameters:
- WIDTH, 200, active pixels per line (>=2)
- HEIGHT, 200, lines per frame (>=1)
- HBLANK, 4, idle cycles between lines (>=1)
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- DRAIN_TIMEOUT, 16, maximum cycles to wait for outstanding gray_valid beats after the last pixel is issued

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start request; ignored while busy=1
- abort  in  1  synchronous frame abort, highest priority after reset
- busy  out  1  high from the cycle after an accepted start until the cycle done is pulsed
- done  out  1  one-cycle pulse at frame end
- err  out  1  level, set with done when the gray count falls short, cleared on next accepted start
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, linear raster index
- mem_rdata  in  24  RAM data, {R[23:16],G[15:8],B[7:0]}, valid the cycle after mem_rd_en
- rgb_valid  out  1  pixel valid to gray datapath
- rgb_hsync  out  1  high on active pixels of a line
- rgb_vsync  out  1  high from the first to the last pixel of a frame, including hblank gaps
- r, g, b  out  8 each  pixel components
- gray_valid  in  1  returned valid from gray datapath
- gray_count  out  ADDR_W+1  gray_valid beats counted in the current frame

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE. busy, done, err, mem_rd_en, rgb_valid, rgb_hsync and rgb_vsync are 0. mem_addr, r, g, b and gray_count are 0.
- FSM states: IDLE, ACTIVE, HBLANK, DRAIN, DONE.
- IDLE: start=1 -> ACTIVE next cycle. On acceptance: clear gray_count and err, zero the pixel/line counters, busy=1.
- ACTIVE: mem_rd_en=1 every cycle; mem_addr = line*WIDTH + col; col increments each cycle.
- ACTIVE, at col=WIDTH-1: if line<HEIGHT-1 -> HBLANK, line increments, col=0; else -> DRAIN.
- HBLANK: mem_rd_en=0 for exactly HBLANK cycles, then -> ACTIVE.
- Output pipeline, fixed 2-cycle latency: mem_rd_en at cycle t -> rgb_valid=1 at cycle t+2, with r/g/b registered from mem_rdata sampled at t+1.
  - rgb_hsync equals rgb_valid.
  - rgb_vsync rises with the first rgb_valid of the frame and falls the cycle after the last rgb_valid.
  - When rgb_valid=0, r/g/b hold their last value.
- gray_count increments on every gray_valid=1 while busy. gray_valid while busy=0 is ignored.
- DRAIN: start a cycle counter once the last rgb_valid has left the pipeline.
  - gray_count == WIDTH*HEIGHT -> DONE with err=0.
  - Counter reaching DRAIN_TIMEOUT first -> DONE with err=1.
  - gray_count exceeding WIDTH*HEIGHT at any point sets err=1; the frame still completes.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE.
- Start arriving in the DONE cycle is ignored. Start is accepted from IDLE only.
- abort=1 in any state:
  - Next cycle: FSM=IDLE, mem_rd_en=0, busy=0, and the pipeline valids and syncs are flushed to 0.
  - done is not pulsed and err is unchanged.
  - abort together with start in IDLE: abort wins.
- Async reset mid-frame: all outputs return to their reset values immediately. No pulse on done.

Test Plan:
- WIDTH=4, HEIGHT=2, HBLANK=2, RAM[i]={i,i+1,i+2}, gray datapath loopback (1-cycle): start -> mem_addr 0..3, 2 gap cycles, 4..7.
  - rgb_valid pattern 1111001111 starting 2 cycles after the first mem_rd_en.
  - r=0..7 in order; rgb_vsync high for 10 cycles; done pulse with err=0; gray_count=8.
- Same setup, gray_valid forced 0: done pulses DRAIN_TIMEOUT cycles after the last rgb_valid with err=1, gray_count=0.
- Start held high for 20 cycles mid-frame: exactly one frame runs and no restart occurs.
  - A new start after the DONE cycle resets err and gray_count to 0.
- Abort at the 3rd pixel of line 1: next cycle mem_rd_en=0, rgb_valid=0, rgb_vsync=0, busy=0, and no done pulse.
  - A subsequent start re-reads from mem_addr=0.
- rst_n pulsed low for 1 ns mid-line (between clock edges): all outputs are 0 at once, FSM=IDLE, and gray_count=0.
- Extra gray_valid pulse injected (9 beats for an 8-pixel frame): err=1 at done, gray_count=9.
